// File: rtl/aes_top.sv
// aes_top: iterative AES-128 encryption core, one round per clock.
// The round key is expanded on the fly alongside the state.
//
// Ports:
//   AES_clk            - system clock, rising edge
//   AES_rst_n          - asynchronous active-low reset
//   AES_en             - start request, level-sampled while idle
//   AES_data_in[127:0] - plaintext, bits 127..120 = byte 0
//   AES_key_in[127:0]  - cipher key, same byte order
//   AES_data_out[127:0]- registered ciphertext
//   AES_data_out_valid - one-cycle pulse marking a new ciphertext
//
// Build option: AES_OUT_CLEAR_EN - when defined, AES_data_out reads 0 in
// every cycle that AES_data_out_valid is low; otherwise it holds the last
// ciphertext.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // (255 - a) * 8 selects entry a counted from the top.
    assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_top (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);
    typedef enum logic {IDLE, BUSY} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] out_q, out_d;
    logic         vld_q, vld_d;

    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // FIPS byte n lives at index 15-n of these packed views.
    logic [15:0][7:0] st_b, sb_b, sr_b, mc_b;
    assign st_b = st_q;

    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (.a(st_b[i]), .y(sb_b[i]));
    end

    // Byte (row r, col c) is FIPS index r + 4c; row r rotates left by r.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr_b[15-(r+4*c)] = sb_b[15-(r+4*((c+r)%4))];
        end
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr_b[15-4*c];
        assign a1 = sr_b[14-4*c];
        assign a2 = sr_b[13-4*c];
        assign a3 = sr_b[12-4*c];
        assign mc_b[15-4*c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        assign mc_b[14-4*c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        assign mc_b[13-4*c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        assign mc_b[12-4*c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end

    // Key schedule: next round key from the current one.
    logic [31:0] rot_w, sub_w, tmp_w, w0, w1, w2, w3;
    logic [7:0]  rcon;
    assign rot_w = {rk_q[23:0], rk_q[31:24]};
    for (genvar k = 0; k < 4; k++) begin : g_ksub
        aes_sbox u_sbox (.a(rot_w[8*k +: 8]), .y(sub_w[8*k +: 8]));
    end

    always_comb begin
        rcon = 8'h00;
        case (rnd_q)
            4'd1:  rcon = 8'h01;
            4'd2:  rcon = 8'h02;
            4'd3:  rcon = 8'h04;
            4'd4:  rcon = 8'h08;
            4'd5:  rcon = 8'h10;
            4'd6:  rcon = 8'h20;
            4'd7:  rcon = 8'h40;
            4'd8:  rcon = 8'h80;
            4'd9:  rcon = 8'h1b;
            4'd10: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign tmp_w = sub_w ^ {rcon, 24'h0};
    assign w0 = rk_q[127:96] ^ tmp_w;
    assign w1 = rk_q[95:64] ^ w0;
    assign w2 = rk_q[63:32] ^ w1;
    assign w3 = rk_q[31:0] ^ w2;

    logic [127:0] rk_next, rnd_out;
    assign rk_next = {w0, w1, w2, w3};
    // Final round skips MixColumns.
    assign rnd_out = ((rnd_q == 4'd10) ? sr_b : mc_b) ^ rk_next;

    always_comb begin
        fsm_d = fsm_q;
        rnd_d = rnd_q;
        st_d  = st_q;
        rk_d  = rk_q;
        vld_d = 1'b0;
`ifdef AES_OUT_CLEAR_EN
        out_d = '0;
`else
        out_d = out_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (AES_en) begin
                    st_d  = AES_data_in ^ AES_key_in;
                    rk_d  = AES_key_in;
                    rnd_d = 4'd1;
                    fsm_d = BUSY;
                end
            end
            BUSY: begin
                st_d = rnd_out;
                rk_d = rk_next;
                if (rnd_q == 4'd10) begin
                    out_d = rnd_out;
                    vld_d = 1'b1;
                    rnd_d = 4'd0;
                    fsm_d = IDLE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm_q <= IDLE;
            rnd_q <= '0;
            st_q  <= '0;
            rk_q  <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            rnd_q <= rnd_d;
            st_q  <= st_d;
            rk_q  <= rk_d;
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign AES_data_out       = out_q;
    assign AES_data_out_valid = vld_q;
endmodule

// File: tb/tb_aes_top.sv
module tb_aes_top;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] key = '0;
    logic [127:0] dout;
    logic         vld;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    int n_pass = 0;
    int n_tot  = 0;

    aes_top dut (
        .AES_clk(clk), .AES_rst_n(rst_n), .AES_en(en),
        .AES_data_in(din), .AES_key_in(key),
        .AES_data_out(dout), .AES_data_out_valid(vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Single-cycle request, then scramble inputs every cycle while busy.
    task automatic run_vec(input string tag, input logic [127:0] k,
                           input logic [127:0] p, input logic [127:0] c);
        int n;
        @(negedge clk);
        key = k; din = p; en = 1'b1;
        @(negedge clk);          // after capture edge E0
        en = 1'b0;
        n = 0;
        while (!vld && n < 20) begin
            din = rnd128(); key = rnd128();
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'd10);
        chk({tag, "_ct"}, dout, c);
        @(negedge clk);
        chk({tag, "_pulse1"}, 128'(vld), 128'd0);
    endtask

    initial begin
        int pulses;
        logic [127:0] hold_exp;

        // Reset state, during and after reset, before any request
        #12;
        chk("rst_out", dout, 128'd0);
        chk("rst_vld", 128'(vld), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_out", dout, 128'd0);
        chk("post_rst_vld", 128'(vld), 128'd0);

        run_vec("v1", K1, P1, C1);
        run_vec("v2", K2, P2, C2);

`ifdef AES_OUT_CLEAR_EN
        hold_exp = 128'd0;
`else
        hold_exp = C2;
`endif
        // Inputs changing while en=0 must not start anything
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            din = (i == 0) ? 128'ha6f2daeb5c0ffee0123456789abcdef0 :
                  (i == 1) ? 128'hd7b262481122334455667788aabbccdd : rnd128();
            key = rnd128();
            @(negedge clk);
            if (vld) pulses++;
        end
        chk("idle_pulses", 128'(pulses), 128'd0);
        chk("idle_hold", dout, hold_exp);

        // Held request: 51 edges high -> captures at E0,11,22,33,44
        @(negedge clk);
        key = K1; din = P1; en = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);      // sampled after edge E_cyc
            if (cyc == 50) en = 1'b0;
            if (vld) begin
                pulses++;
                chk("held_ct", dout, C1);
                chk("held_phase", 128'((cyc - 10) % 11), 128'd0);
            end
        end
        chk("held_count", 128'(pulses), 128'd5);
`ifdef AES_OUT_CLEAR_EN
        chk("held_hold", dout, 128'd0);
`else
        chk("held_hold", dout, C1);
`endif

        // Reset in the middle of a block
        @(negedge clk);
        key = K2; din = P2; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);   // around round 5
        rst_n = 1'b0;
        #1;
        chk("midrst_out", dout, 128'd0);
        chk("midrst_vld", 128'(vld), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (vld) pulses++;
        end
        chk("midrst_nopulse", 128'(pulses), 128'd0);
        chk("midrst_out2", dout, 128'd0);
        run_vec("after_rst", K1, P1, C1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
